// File: rtl/stream_mux2.sv
// stream_mux2: two-input packet stream multiplexer.
// A grant is held for a whole packet; round-robin picks between
// simultaneously pending channels, with one arbitration cycle per packet.
module stream_mux2 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_0,
    input  logic              last_0,
    input  logic [DATA_W-1:0] data_0,
    output logic              ready_0,
    input  logic              valid_1,
    input  logic              last_1,
    input  logic [DATA_W-1:0] data_1,
    output logic              ready_1,
    output logic              valid_out,
    output logic              last_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready_in,
    input  logic              ready_out
);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   rr;        // channel preferred on the next tie
    logic   rr_nxt;
    logic   sink_ok;

    assign sink_ok = ready_in & ready_out;

    // State and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr    <= 1'b0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
        end
    end

    // Next-state arbitration and combinational output steering
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        valid_out = 1'b0;
        last_out  = 1'b0;
        data_out  = '0;
        ready_0   = 1'b0;
        ready_1   = 1'b0;

        case (state)
            IDLE: begin
                if (valid_0 && !valid_1) begin
                    state_nxt = GNT0;
                end else if (valid_1 && !valid_0) begin
                    state_nxt = GNT1;
                end else if (valid_0 && valid_1) begin
                    state_nxt = rr ? GNT1 : GNT0;
                end
            end

            GNT0: begin
                valid_out = valid_0;
                last_out  = last_0;
                data_out  = data_0;
                ready_0   = sink_ok;
                // last_0 only counts on an accepted beat
                if (valid_0 && sink_ok && last_0) begin
                    state_nxt = IDLE;
                    rr_nxt    = 1'b1;
                end
            end

            GNT1: begin
                valid_out = valid_1;
                last_out  = last_1;
                data_out  = data_1;
                ready_1   = sink_ok;
                if (valid_1 && sink_ok && last_1) begin
                    state_nxt = IDLE;
                    rr_nxt    = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stream_mux2.sv
// tb_stream_mux2: directed and randomized checks of stream_mux2 against a
// packet-level reference model (grant owner, round-robin preference, queues).
module tb_stream_mux2;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_0, last_0, ready_0;
    logic [7:0] data_0;
    logic       valid_1, last_1, ready_1;
    logic [7:0] data_1;
    logic       valid_out, last_out;
    logic [7:0] data_out;
    logic       ready_in, ready_out;

    stream_mux2 #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_0   (valid_0),
        .last_0    (last_0),
        .data_0    (data_0),
        .ready_0   (ready_0),
        .valid_1   (valid_1),
        .last_1    (last_1),
        .data_1    (data_1),
        .ready_1   (ready_1),
        .valid_out (valid_out),
        .last_out  (last_out),
        .data_out  (data_out),
        .ready_in  (ready_in),
        .ready_out (ready_out)
    );

    always #5 clk = ~clk;

    // Source queues (beats still to be offered) and per-channel logs
    beat_t q0[$], q1[$];
    beat_t sent0[$], sent1[$];
    beat_t rx0[$], rx1[$];

    // Reference model: owner of the output (-1 = nobody) and tie preference
    int g;
    bit rr;

    // Percent probabilities for random stimulus
    int pv0, pv1, pri, pro;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int ch, input int len, input int base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = (base < 0) ? 8'($urandom) : 8'(base + i);
            b.l = (i == len - 1);
            if (ch == 0) begin
                q0.push_back(b);
                sent0.push_back(b);
            end else begin
                q1.push_back(b);
                sent1.push_back(b);
            end
        end
    endtask

    task automatic drive();
        valid_0 = (q0.size() > 0) && ($urandom_range(99) < pv0);
        valid_1 = (q1.size() > 0) && ($urandom_range(99) < pv1);
        if (q0.size() > 0) begin
            data_0 = q0[0].d;
            last_0 = q0[0].l;
        end else begin
            data_0 = 8'($urandom);
            last_0 = 1'($urandom);
        end
        if (q1.size() > 0) begin
            data_1 = q1[0].d;
            last_1 = q1[0].l;
        end else begin
            data_1 = 8'($urandom);
            last_1 = 1'($urandom);
        end
        ready_in  = ($urandom_range(99) < pri);
        ready_out = ($urandom_range(99) < pro);
    endtask

    // Compare all outputs against the model view, and log accepted beats
    task automatic sample();
        logic       ev, el, er0, er1;
        logic [7:0] ed;
        beat_t      b;
        #1;
        ev = 1'b0; el = 1'b0; ed = 8'h00; er0 = 1'b0; er1 = 1'b0;
        if (g == 0) begin
            ev = valid_0; el = last_0; ed = data_0; er0 = ready_in & ready_out;
        end else if (g == 1) begin
            ev = valid_1; el = last_1; ed = data_1; er1 = ready_in & ready_out;
        end
        check("valid_out", 32'(valid_out), 32'(ev));
        check("last_out",  32'(last_out),  32'(el));
        check("data_out",  32'(data_out),  32'(ed));
        check("ready_0",   32'(ready_0),   32'(er0));
        check("ready_1",   32'(ready_1),   32'(er1));
        check("ready_excl", 32'(ready_0 & ready_1), 32'd0);
        if (valid_out && ready_in && ready_out) begin
            b.d = data_out;
            b.l = last_out;
            if (ready_0) rx0.push_back(b);
            else if (ready_1) rx1.push_back(b);
        end
    endtask

    task automatic tick();
        bit v, l;
        @(posedge clk);
        if (!rst_n) begin
            g  = -1;
            rr = 1'b0;
        end else if (g < 0) begin
            if (valid_0 && valid_1) g = int'(rr);
            else if (valid_0) g = 0;
            else if (valid_1) g = 1;
        end else begin
            v = (g == 0) ? valid_0 : valid_1;
            l = (g == 0) ? last_0 : last_1;
            if (v && ready_in && ready_out) begin
                if (g == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                if (l) begin
                    rr = (g == 0);
                    g  = -1;
                end
            end
        end
        #1;
    endtask

    task automatic cycle();
        drive();
        sample();
        tick();
    endtask

    task automatic flush();
        q0.delete(); q1.delete();
        sent0.delete(); sent1.delete();
        rx0.delete(); rx1.delete();
    endtask

    // Run until both sources are empty and the model is idle, bounded
    task automatic drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && g < 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        check({tag, "_drained"}, 32'(q0.size() + q1.size()), 32'd0);
        check({tag, "_rx0_len"}, 32'(rx0.size()), 32'(sent0.size()));
        check({tag, "_rx1_len"}, 32'(rx1.size()), 32'(sent1.size()));
        for (int i = 0; i < rx0.size() && i < sent0.size(); i++)
            check({tag, "_rx0_beat"}, {23'd0, rx0[i].l, rx0[i].d}, {23'd0, sent0[i].l, sent0[i].d});
        for (int i = 0; i < rx1.size() && i < sent1.size(); i++)
            check({tag, "_rx1_beat"}, {23'd0, rx1[i].l, rx1[i].d}, {23'd0, sent1[i].l, sent1[i].d});
        flush();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive();
        sample();
        tick();
        rst_n = 1'b1;
        flush();
    endtask

    initial begin
        g = -1; rr = 1'b0;
        pv0 = 100; pv1 = 100; pri = 100; pro = 100;
        rst_n = 1'b0;
        valid_0 = 1'b1; last_0 = 1'b1; data_0 = 8'h5A;
        valid_1 = 1'b1; last_1 = 1'b1; data_1 = 8'hC3;
        ready_in = 1'b1; ready_out = 1'b1;

        // Reset state with busy inputs: everything must be quiet
        #2;
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_ready_0",   32'(ready_0),   32'd0);
        check("rst_ready_1",   32'(ready_1),   32'd0);
        do_reset();

        // Single-channel 4-beat packet 0x01..0x04
        add_pkt(0, 4, 1);
        drain("ch0_4beat", 20);

        // Both channels saturated after reset: alternating ch0 (4) / ch1 (6)
        do_reset();
        for (int i = 0; i < 3; i++) begin
            add_pkt(0, 4, -1);
            add_pkt(1, 6, -1);
        end
        drain("alternate", 100);

        // ready_out low for 3 cycles in the middle of a ch1 packet
        add_pkt(1, 6, 8'h40);
        for (int i = 0; i < 3; i++) cycle();
        pro = 0;
        for (int i = 0; i < 3; i++) cycle();
        pro = 100;
        drain("stall", 30);

        // valid_0 drops for 2 cycles mid-packet while ch1 waits
        add_pkt(0, 6, 8'h10);
        add_pkt(1, 3, 8'h80);
        for (int i = 0; i < 3; i++) cycle();
        pv0 = 0;
        for (int i = 0; i < 2; i++) cycle();
        pv0 = 100;
        drain("v0_gap", 30);

        // Single-beat packet on ch1
        add_pkt(1, 1, 8'hA5);
        drain("single", 10);

        // Asynchronous reset on beat 3 of a ch1 packet
        add_pkt(1, 6, 8'h20);
        for (int i = 0; i < 3; i++) cycle();
        drive();
        sample();
        check("pre_rst_beat3", 32'(data_out), 32'h22);
        rst_n = 1'b0;
        g = -1; rr = 1'b0;
        #1;
        check("async_valid_out", 32'(valid_out), 32'd0);
        check("async_data_out",  32'(data_out),  32'd0);
        check("async_ready_1",   32'(ready_1),   32'd0);
        tick();
        flush();
        rst_n = 1'b1;
        add_pkt(0, 3, -1);
        add_pkt(1, 3, -1);
        cycle();
        drive();
        sample();
        check("post_rst_ch0_first", 32'(ready_0), 32'd1);
        tick();
        drain("post_rst", 30);

        // Randomized traffic with gaps and back-pressure
        pv0 = 70; pv1 = 70; pri = 80; pro = 85;
        for (int i = 0; i < 8; i++) begin
            add_pkt(0, $urandom_range(1, 5), -1);
            add_pkt(1, $urandom_range(1, 5), -1);
        end
        drain("random", 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
